// File: rtl/ac_sum_decoder.sv
// ac_sum_decoder: watches an accumulator's running sum and recovers each
// per-sample increment as a modular difference. Steps that cannot be a legal
// IN_W-bit increment are flagged and counted. Legal increments are queued in
// a small ready/valid FIFO.
module ac_sum_decoder #(
    parameter int SUM_W      = 16,
    parameter int IN_W       = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SUM_W-1:0]     sum_in,
    input  logic                 sum_valid,
    input  logic                 resync,
    output logic [IN_W-1:0]      dec_data,
    output logic                 dec_valid,
    input  logic                 dec_ready,
    output logic                 err_delta,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 overflow,
    output logic [15:0]          sample_count,
    output logic                 synced
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        ST_SYNC  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SUM_W-1:0]       prev_sum_q, prev_sum_d;
    logic [SUM_W-1:0]       delta;
    logic                   delta_legal;
    logic                   push_req;
    logic                   step_err;

    logic [IN_W-1:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [IN_W-1:0]        dec_data_q, dec_data_d;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop_en;
    logic                   push_en;
    logic                   push_drop;
    logic [FIFO_DEPTH-1:0]  wr_sel;

    logic                   err_delta_q;
    logic [ERR_CNT_W-1:0]   err_count_q;
    logic                   overflow_q;
    logic [15:0]            sample_count_q;

    // Modular difference: wrap-around of the sum stream falls out of the
    // unsigned subtraction, so only the upper bits decide legality.
    assign delta       = sum_in - prev_sum_q;
    assign delta_legal = (delta[SUM_W-1:IN_W] == '0);

    // Next-state logic: baseline capture, step classification and resync.
    always_comb begin
        state_d    = state_q;
        prev_sum_d = prev_sum_q;
        push_req   = 1'b0;
        step_err   = 1'b0;
        if (sum_valid) begin
            prev_sum_d = sum_in;
            state_d    = ST_TRACK;
            if (!resync && state_q == ST_TRACK) begin
                push_req = delta_legal;
                step_err = !delta_legal;
            end
        end else if (resync) begin
            state_d = ST_SYNC;
        end
    end

    // State and baseline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_SYNC;
            prev_sum_q <= '0;
        end else begin
            state_q    <= state_d;
            prev_sum_q <= prev_sum_d;
        end
    end

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign pop_en     = !fifo_empty && dec_ready;
    // A full FIFO still accepts a push when a pop frees a slot the same cycle.
    assign push_en    = push_req && (!fifo_full || pop_en);
    assign push_drop  = push_req && fifo_full && !pop_en;

    // Per-entry write strobes for the storage array.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = push_en && (wr_ptr_q == PTR_W'(gi));
        end
    endgenerate

    // FIFO pointer/occupancy update and the registered head value. The head
    // register keeps its last value once the FIFO drains.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        dec_data_d = dec_data_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_en && !pop_en) begin
            count_d = count_q + 1'b1;
        end else if (!push_en && pop_en) begin
            count_d = count_q - 1'b1;
        end
        if (count_d != '0) begin
            // The freshly pushed word is the head only when it lands at the
            // new read position (FIFO otherwise empty after this cycle's pop).
            if (push_en && wr_ptr_q == rd_ptr_d) begin
                dec_data_d = delta[IN_W-1:0];
            end else begin
                dec_data_d = mem_q[rd_ptr_d];
            end
        end
    end

    // Storage array: no reset, written only through the strobes.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (wr_sel[i]) begin
                mem_q[i] <= delta[IN_W-1:0];
            end
        end
    end

    // FIFO control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            dec_data_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            dec_data_q <= dec_data_d;
        end
    end

    // Status: error pulse, saturating error count, sticky overflow and the
    // wrapping count of legal deltas (dropped ones included).
    always_ff @(posedge clk) begin
        if (rst) begin
            err_delta_q    <= 1'b0;
            err_count_q    <= '0;
            overflow_q     <= 1'b0;
            sample_count_q <= '0;
        end else begin
            err_delta_q <= step_err;
            if (step_err && err_count_q != '1) begin
                err_count_q <= err_count_q + 1'b1;
            end
            if (push_drop) begin
                overflow_q <= 1'b1;
            end
            if (push_req) begin
                sample_count_q <= sample_count_q + 16'd1;
            end
        end
    end

    assign dec_data     = dec_data_q;
    assign dec_valid    = !fifo_empty;
    assign err_delta    = err_delta_q;
    assign err_count    = err_count_q;
    assign overflow     = overflow_q;
    assign sample_count = sample_count_q;
    assign synced       = (state_q == ST_TRACK);

endmodule

// File: tb/tb_ac_sum_decoder.sv
// Testbench for ac_sum_decoder: directed scenarios followed by randomized
// traffic, every cycle compared against a queue-based reference model.
module tb_ac_sum_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] sum_in = '0;
    logic        sum_valid = 1'b0;
    logic        resync = 1'b0;
    logic [7:0]  dec_data;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic        err_delta;
    logic [7:0]  err_count;
    logic        overflow;
    logic [15:0] sample_count;
    logic        synced;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int q[$];
    int m_prev = 0;
    bit m_sync = 0;
    int m_err = 0;
    bit m_ovf = 0;
    int m_cnt = 0;
    int m_last = 0;
    bit m_errp = 0;

    ac_sum_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .sum_in       (sum_in),
        .sum_valid    (sum_valid),
        .resync       (resync),
        .dec_data     (dec_data),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .err_delta    (err_delta),
        .err_count    (err_count),
        .overflow     (overflow),
        .sample_count (sample_count),
        .synced       (synced)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, advance the model at the edge, compare.
    task automatic cyc(input bit r, input bit sv, input int s, input bit rs, input bit rdy);
        bit pop;
        bit push;
        int d;
        int tmp;
        rst       = r;
        sum_valid = sv;
        sum_in    = s[15:0];
        resync    = rs;
        dec_ready = rdy;
        @(posedge clk);
        push = 0;
        d    = 0;
        if (r) begin
            q.delete();
            m_prev = 0; m_sync = 0; m_err = 0; m_ovf = 0;
            m_cnt = 0; m_last = 0; m_errp = 0;
        end else begin
            pop    = (q.size() > 0) && rdy;
            m_errp = 0;
            if (sv) begin
                if (rs || !m_sync) begin
                    m_sync = 1;
                end else begin
                    d = ((s & 'hFFFF) - m_prev) & 'hFFFF;
                    if (d < 256) begin
                        m_cnt = (m_cnt + 1) % 65536;
                        push  = 1;
                    end else begin
                        m_errp = 1;
                        if (m_err < 255) m_err++;
                    end
                end
                m_prev = s & 'hFFFF;
            end else if (rs) begin
                m_sync = 0;
            end
            if (pop) tmp = q.pop_front();
            if (push) begin
                if (q.size() == 4) m_ovf = 1;
                else q.push_back(d);
            end
            if (q.size() > 0) m_last = q[0];
        end
        #1;
        check_val("dec_valid",    int'(dec_valid),    int'(q.size() > 0));
        check_val("dec_data",     int'(dec_data),     m_last);
        check_val("err_delta",    int'(err_delta),    int'(m_errp));
        check_val("err_count",    int'(err_count),    m_err);
        check_val("overflow",     int'(overflow),     int'(m_ovf));
        check_val("sample_count", int'(sample_count), m_cnt);
        check_val("synced",       int'(synced),       int'(m_sync));
        $display("cyc rst=%0b sv=%0b sum=%04h rs=%0b rdy=%0b -> valid=%0b data=%02h err=%0b ecnt=%0d ovf=%0b scnt=%0d sync=%0b",
                 r, sv, s[15:0], rs, rdy, dec_valid, dec_data, err_delta, err_count,
                 overflow, sample_count, synced);
    endtask

    int acc;

    initial begin
        // Reset state
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);

        // Basic: baseline 0, +5, illegal +0x100, +0
        cyc(0, 1, 'h0000, 0, 1);
        cyc(0, 1, 'h0005, 0, 1);
        cyc(0, 1, 'h0105, 0, 1);
        cyc(0, 1, 'h0105, 0, 1);
        cyc(0, 0, 0, 0, 1);

        // Wrap-around: 0xFFF0 -> 0x0005 is +0x15
        cyc(0, 1, 'hFFF0, 1, 1);
        cyc(0, 1, 'h0005, 0, 1);
        cyc(0, 0, 0, 0, 1);

        // Boundary deltas 255 (legal) and 256 (illegal)
        cyc(0, 1, 'h0104, 0, 1);
        cyc(0, 1, 'h0204, 0, 1);

        // Backpressure: five deltas 1..5 into depth 4, then drain
        cyc(0, 1, 'h0005, 1, 0);
        cyc(0, 1, 'h0006, 0, 0);
        cyc(0, 1, 'h0008, 0, 0);
        cyc(0, 1, 'h000B, 0, 0);
        cyc(0, 1, 'h000F, 0, 0);
        cyc(0, 1, 'h0014, 0, 0);
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1);

        // Full with simultaneous push and pop (fresh reset clears overflow)
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 'h0100, 0, 0);
        for (int i = 1; i <= 4; i++) cyc(0, 1, 'h0100 + i * 10, 0, 0);
        cyc(0, 1, 'h0180, 0, 1);
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1);

        // resync with and without a sample
        cyc(0, 1, 'h1234, 1, 1);
        cyc(0, 1, 'h1240, 0, 1);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 1, 'h1250, 0, 1);
        cyc(0, 1, 'h1251, 0, 1);

        // Reset mid-stream with three entries held and seven errors
        for (int i = 0; i < 7; i++) cyc(0, 1, (i % 2) ? 'h0000 : 'h8000, 0, 0);
        cyc(0, 1, 'h0001, 0, 0);
        cyc(0, 1, 'h0002, 0, 0);
        cyc(0, 1, 'h0003, 0, 0);
        cyc(1, 1, 'h0010, 0, 0);
        cyc(0, 1, 'h0020, 0, 1);
        cyc(0, 1, 'h0021, 0, 1);

        // 300 illegal steps: error counter saturates
        for (int i = 0; i < 300; i++) cyc(0, 1, (i % 2) ? 'h0021 : 'h9021, 0, 1);
        cyc(0, 0, 0, 0, 1);

        // Randomized traffic
        cyc(1, 0, 0, 0, 0);
        acc = 0;
        for (int i = 0; i < 3000; i++) begin
            bit r, sv, rs, rdy;
            int k;
            r   = ($urandom_range(0, 499) == 0);
            sv  = ($urandom_range(0, 3) != 0);
            rs  = ($urandom_range(0, 29) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            if (sv) begin
                k = $urandom_range(0, 19);
                if (k == 0)      acc = $urandom;
                else if (k == 1) acc = acc + 256 + $urandom_range(0, 1000);
                else if (k == 2) acc = acc + 255;
                else if (k == 3) acc = acc;
                else             acc = acc + $urandom_range(0, 255);
                acc = acc & 'hFFFF;
            end
            cyc(r, sv, acc, rs, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
